// File: rtl/led_matrix_scanner.sv
// Row-multiplexed, double-buffered scanner for an N x N LED matrix driven from a flat cell vector.
// Define LED_SCAN_BLANK_EN to insert one blank tick between rows (anti-ghosting).
module led_matrix_scanner #(
    parameter int N       = 5,
    parameter int DIVIDER = 1000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [N*N-1:0] cells,
    input  logic           load,
    output logic [N-1:0]   rows,
    output logic [N-1:0]   cols,
    output logic           frame_start
);

    localparam int R_W = (N > 1) ? $clog2(N) : 1;
    localparam int C_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

`ifdef LED_SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;
`else
    typedef enum logic {IDLE, DRIVE} state_t;
`endif

    state_t         state;
    logic [R_W-1:0] r;
    logic [C_W-1:0] count;
    logic [N*N-1:0] pend;
    logic [N*N-1:0] fb;

    logic           tick;
    logic [N*N-1:0] frame_img;
    logic [R_W-1:0] r_adv;
    logic [N*N-1:0] fb_adv;
    logic [N-1:0]   rows_adv;
    logic [N-1:0]   cols_adv;
    logic           fs_adv;

    // Everything needed to step to the next row, precomputed so the outputs can be registered
    // with the values they will show rather than lagging the state by a cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        r_adv    = '0;
        fb_adv   = fb;
        rows_adv = '0;
        fs_adv   = 1'b0;
        tick      = (count == C_W'(DIVIDER - 1));
        frame_img = load ? cells : pend;
        if (r == R_W'(N - 1)) begin
            fb_adv = frame_img;
            fs_adv = 1'b1;
        end else begin
            r_adv = r + R_W'(1);
        end
        rows_adv[r_adv] = 1'b1;
        cols_adv = ~fb_adv[int'(r_adv) * N +: N];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: both image buffers are real registers and are cleared on reset, so a
            // restarted scan never shows a stale picture.
            state       <= IDLE;
            r           <= '0;
            count       <= '0;
            pend        <= '0;
            fb          <= '0;
            rows        <= '0;
            cols        <= '1;
            frame_start <= 1'b0;
        end else begin
            if (load)
                pend <= cells;
            frame_start <= 1'b0;

            if (!ena) begin
                state <= IDLE;
                r     <= '0;
                count <= '0;
                rows  <= '0;
                cols  <= '1;
            end else begin
                case (state)
                    IDLE: begin
                        // Entering the scan is a frame boundary: latch the image and show row 0.
                        state       <= DRIVE;
                        r           <= '0;
                        count       <= '0;
                        fb          <= frame_img;
                        rows        <= N'(1);
                        cols        <= ~frame_img[N-1:0];
                        frame_start <= 1'b1;
                    end
                    DRIVE: begin
                        count <= tick ? '0 : count + C_W'(1);
                        if (tick) begin
`ifdef LED_SCAN_BLANK_EN
                            state <= BLANK;
                            rows  <= '0;
                            cols  <= '1;
`else
                            r           <= r_adv;
                            fb          <= fb_adv;
                            rows        <= rows_adv;
                            cols        <= cols_adv;
                            frame_start <= fs_adv;
`endif
                        end
                    end
`ifdef LED_SCAN_BLANK_EN
                    BLANK: begin
                        count <= tick ? '0 : count + C_W'(1);
                        if (tick) begin
                            state       <= DRIVE;
                            r           <= r_adv;
                            fb          <= fb_adv;
                            rows        <= rows_adv;
                            cols        <= cols_adv;
                            frame_start <= fs_adv;
                        end
                    end
`endif
                    default: begin
                        state <= IDLE;
                        rows  <= '0;
                        cols  <= '1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench: two scanners (DIVIDER=1 and DIVIDER=3) share stimulus and are compared every
// cycle against a phase-based reference model; directed literal checks pin the model.
module tb_led_matrix_scanner;

    localparam int N = 5;
    localparam int NI = 2;
`ifdef LED_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    logic           load;
    logic [N*N-1:0] cells;
    logic [N-1:0]   rows1, cols1, rows3, cols3;
    logic           fs1, fs3;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    led_matrix_scanner #(.N(N), .DIVIDER(1)) u_d1 (
        .clk(clk), .rst(rst), .ena(ena), .cells(cells), .load(load),
        .rows(rows1), .cols(cols1), .frame_start(fs1)
    );

    led_matrix_scanner #(.N(N), .DIVIDER(3)) u_d3 (
        .clk(clk), .rst(rst), .ena(ena), .cells(cells), .load(load),
        .rows(rows3), .cols(cols3), .frame_start(fs3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since the scan started determine row, blanking and frame edges.
    int             div_of [NI] = '{1, 3};
    bit             m_act  [NI];
    int             m_ph   [NI];
    logic [N*N-1:0] m_pend [NI];
    logic [N*N-1:0] m_fb   [NI];
    logic [N-1:0]   e_rows [NI];
    logic [N-1:0]   e_cols [NI];
    logic           e_fs   [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_act[i]  = 1'b0;
                m_ph[i]   = 0;
                m_pend[i] = '0;
                m_fb[i]   = '0;
                e_rows[i] = '0;
                e_cols[i] = '1;
                e_fs[i]   = 1'b0;
            end else begin
                if (!ena) begin
                    m_act[i]  = 1'b0;
                    e_rows[i] = '0;
                    e_cols[i] = '1;
                    e_fs[i]   = 1'b0;
                end else begin
                    int rowp, frame, pos, row;
                    bit blank;
                    if (!m_act[i]) begin
                        m_act[i] = 1'b1;
                        m_ph[i]  = 0;
                    end else begin
                        m_ph[i]++;
                    end
                    rowp  = BLANK_EN ? 2 * div_of[i] : div_of[i];
                    frame = N * rowp;
                    pos   = m_ph[i] % frame;
                    if (pos == 0)
                        m_fb[i] = load ? cells : m_pend[i];
                    row   = pos / rowp;
                    blank = BLANK_EN && ((pos % rowp) >= div_of[i]);
                    e_rows[i] = blank ? '0 : N'(1 << row);
                    e_cols[i] = blank ? '1 : ~m_fb[i][row * N +: N];
                    e_fs[i]   = (pos == 0);
                end
                if (load)
                    m_pend[i] = cells;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("d1_rows", 32'(rows1), 32'(e_rows[0]));
            check("d1_cols", 32'(cols1), 32'(e_cols[0]));
            check("d1_fs",   32'(fs1),   32'(e_fs[0]));
            check("d3_rows", 32'(rows3), 32'(e_rows[1]));
            check("d3_cols", 32'(cols3), 32'(e_cols[1]));
            check("d3_fs",   32'(fs3),   32'(e_fs[1]));
        end
    end

    initial begin
        rst   = 1'b1;
        ena   = 1'b0;
        load  = 1'b0;
        cells = '0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_rows", 32'(rows1), 32'h0);
        check("reset_cols", 32'(cols1), 32'h1F);
        check("reset_fs",   32'(fs1),   32'h0);

        // Start with all cells lit, loaded on the entry cycle (bypass into the frame buffer).
        ena   = 1'b1;
        load  = 1'b1;
        cells = 25'h1FFFFFF;
        @(negedge clk);
        load  = 1'b0;
        cells = '0;
        check("entry_rows", 32'(rows1), 32'h01);
        check("entry_cols", 32'(cols1), 32'h00);
        check("entry_fs",   32'(fs1),   32'h1);
        check("model_entry_rows", 32'(e_rows[0]), 32'h01);
`ifndef LED_SCAN_BLANK_EN
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            check("walk_rows", 32'(rows1), 32'(1 << i));
            check("walk_cols", 32'(cols1), 32'h00);
            check("walk_fs",   32'(fs1),   32'h0);
        end
        @(negedge clk);
        check("wrap_rows", 32'(rows1), 32'h01);
        check("wrap_fs",   32'(fs1),   32'h1);
        repeat (3) @(negedge clk);
        check("row3_rows", 32'(rows1), 32'h08);

        // Drop ena during row 3: blank on the next cycle.
        ena = 1'b0;
        @(negedge clk);
        check("off_rows", 32'(rows1), 32'h00);
        check("off_cols", 32'(cols1), 32'h1F);
        check("off_fs",   32'(fs1),   32'h0);

        // Re-raise ena with a load on the entry cycle: row 0 shows the bypassed image.
        ena   = 1'b1;
        load  = 1'b1;
        cells = 25'h00000AA;
        @(negedge clk);
        load = 1'b0;
        check("bypass_rows", 32'(rows1), 32'h01);
        check("bypass_cols", 32'(cols1), 32'h15);
        check("bypass_fs",   32'(fs1),   32'h1);
        @(negedge clk);
        check("bypass_row1_cols", 32'(cols1), 32'h1A);
        check("d3_hold_rows",     32'(rows3), 32'h01);
        check("d3_hold_cols",     32'(cols3), 32'h15);
`else
        @(negedge clk);
        check("blank_rows", 32'(rows1), 32'h00);
        check("blank_cols", 32'(cols1), 32'h1F);
        @(negedge clk);
        check("row1_rows", 32'(rows1), 32'h02);
`endif

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 499) == 0);
            ena   = ($urandom_range(0, 39) != 0);
            load  = ($urandom_range(0, 9) == 0);
            cells = 25'($urandom);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
